rf_wport_arb: RTL

//  Shares the single register-file write port between the WB stage and a long-latency unit
//  (LU: divider/multiplier result return). WB always wins the port; LU results are buffered
//  in a small FIFO and drained on free cycles. Sits between wb_stage/LU and regfile.

---
 rtl/rf_wport_arb_pkg.sv | 41 ++++
 rtl/rf_wport_arb_fifo.sv | 83 ++++++++
 rtl/rf_wport_arb.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/rf_wport_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rf_wport_arb_pkg
//  Description : Shared types and constants for the register-file write-port
//                arbiter: the buffered LU entry layout, the rf_* bundle and a
//                dest-to-mask helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package rf_wport_arb_pkg;

    // Buffered LU entry: valid + dest + data
    localparam int RF_WPORT_ENTRY_WD = 38;
    localparam int RF_ENT_DATA_LSB   = 0;
    localparam int RF_ENT_DEST_LSB   = 32;
    localparam int RF_ENT_VALID_POS  = 37;

    // rf_* bundle toward the register file: we + waddr + wdata
    localparam int WS_TO_RF_BUS_WD   = 38;

    typedef struct packed {
        logic        valid;
        logic [4:0]  dest;
        logic [31:0] data;
    } rf_entry_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } rf_bus_t;

    // One-hot register mask; r0 never appears as pending.
    function automatic logic [31:0] dest_onehot(input logic [4:0] dest);
        logic [31:0] m;
        m = '0;
        if (dest != 5'd0) m[dest] = 1'b1;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rf_wport_arb_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : rf_arb_fifo
//  Description : DEPTH x 38-bit FIFO holding LU results waiting for the RF
//                write port. Entries can be invalidated in place by dest
//                match (WAW squash); an invalid entry still occupies its slot.
//  Ports       : clk, resetn (async, active low)
//                push / push_entry : write entry at tail
//                pop               : retire head entry
//                sq_en / sq_dest   : clear valid of every entry with that dest
//                head              : current head entry
//                count             : occupancy
//                nxt_valid/nxt_dest: storage contents as of the next edge
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_arb_fifo
    import rf_wport_arb_pkg::*;
#(
    parameter int DEPTH = 2
)
(
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  rf_entry_t                push_entry,
    input  logic                     pop,
    input  logic                     sq_en,
    input  logic [4:0]               sq_dest,
    output rf_entry_t                head,
    output logic [$clog2(DEPTH):0]   count,
    output logic [DEPTH-1:0]         nxt_valid,
    output logic [DEPTH*5-1:0]       nxt_dest
);

    localparam int PTR_W = $clog2(DEPTH);

    rf_entry_t          r_mem [DEPTH];
    rf_entry_t          w_nxt_mem [DEPTH];
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W:0]     r_count;

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;

    // Squash first, then retire the head, then write the tail. A popped slot
    // has its valid cleared so unoccupied slots never contribute to the mask.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_nxt_mem[i] = r_mem[i];
            if (sq_en && r_mem[i].valid && (r_mem[i].dest == sq_dest))
                w_nxt_mem[i].valid = 1'b0;
        end
        if (pop)  w_nxt_mem[r_rd_ptr].valid = 1'b0;
        if (push) w_nxt_mem[r_wr_ptr]       = push_entry;
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_nxt
        assign nxt_valid[g]         = w_nxt_mem[g].valid;
        assign nxt_dest[g*5 +: 5]   = w_nxt_mem[g].dest;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= w_nxt_mem[i];
            // DEPTH is a power of two, so natural pointer overflow wraps.
            if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/rf_wport_arb.sv
`default_nettype none
// ============================================================================
//  Module      : rf_wport_arb
//  Description : Shares the register-file write port between the WB stage
//                (always wins) and long-latency unit results, which are
//                bypassed when the port is free or buffered otherwise.
//                Exports a registered pending-dest mask for ID interlock.
//  Ports       : ws_rf_*   WB write request
//                lu_*      LU result handshake (lu_ready out)
//                rf_*      register-file write port
//                pend_mask buffered valid destinations (bit 0 always 0)
//                arb_count FIFO occupancy
//                arb_stall_req pipeline freeze request
//  Options     : RF_ARB_STARVE_GUARD_EN - enables the starvation counter that
//                drives arb_stall_req; undefined ties arb_stall_req to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_wport_arb
    import rf_wport_arb_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_LIM = 8
)
(
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    ws_rf_we,
    input  logic [4:0]              ws_rf_waddr,
    input  logic [31:0]             ws_rf_wdata,
    input  logic                    lu_valid,
    input  logic [4:0]              lu_dest,
    input  logic [31:0]             lu_data,
    output logic                    lu_ready,
    output logic                    rf_we,
    output logic [4:0]              rf_waddr,
    output logic [31:0]             rf_wdata,
    output logic [31:0]             pend_mask,
    output logic [$clog2(DEPTH):0]  arb_count,
    output logic                    arb_stall_req
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("rf_wport_arb: DEPTH must be a power of two >= 2");
    end
    if (STARVE_LIM < 1) begin : g_bad_lim
        $error("rf_wport_arb: STARVE_LIM must be >= 1");
    end

    logic               w_fifo_empty;
    logic               w_lu_acc;
    logic               w_lu_live;
    logic               w_pop;
    logic               w_bypass;
    logic               w_push;
    rf_entry_t          w_push_entry;
    rf_entry_t          w_head;
    logic [DEPTH-1:0]   w_nxt_valid;
    logic [DEPTH*5-1:0] w_nxt_dest;
    logic [31:0]        w_pend_nxt;
    logic [31:0]        r_pend_mask;

    assign w_fifo_empty = (arb_count == '0);
    assign lu_ready     = (arb_count != CNT_W'(DEPTH));
    assign w_lu_acc     = lu_valid && lu_ready;
    // A dest-0 result is accepted but then simply dropped.
    assign w_lu_live    = w_lu_acc && (lu_dest != 5'd0);

    assign w_pop    = !ws_rf_we && !w_fifo_empty;
    assign w_bypass = !ws_rf_we && w_fifo_empty && w_lu_live;
    assign w_push   = w_lu_live && !w_bypass;

    // WB is younger: an LU result for the same register arriving alongside a
    // WB write is stored already dead.
    assign w_push_entry.valid = !(ws_rf_we && (lu_dest == ws_rf_waddr));
    assign w_push_entry.dest  = lu_dest;
    assign w_push_entry.data  = lu_data;

    rf_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .push       (w_push),
        .push_entry (w_push_entry),
        .pop        (w_pop),
        .sq_en      (ws_rf_we),
        .sq_dest    (ws_rf_waddr),
        .head       (w_head),
        .count      (arb_count),
        .nxt_valid  (w_nxt_valid),
        .nxt_dest   (w_nxt_dest)
    );

    // Port select: WB, then FIFO head (bubble idles the port), then bypass.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = ws_rf_waddr;
        rf_wdata = ws_rf_wdata;
        if (ws_rf_we) begin
            rf_we = 1'b1;
        end else if (!w_fifo_empty) begin
            rf_we    = w_head.valid;
            rf_waddr = w_head.dest;
            rf_wdata = w_head.data;
        end else if (w_bypass) begin
            rf_we    = 1'b1;
            rf_waddr = lu_dest;
            rf_wdata = lu_data;
        end
    end

    always_comb begin
        w_pend_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_nxt_valid[i]) w_pend_nxt = w_pend_nxt | dest_onehot(w_nxt_dest[i*5 +: 5]);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_pend_mask <= '0;
        else         r_pend_mask <= w_pend_nxt;
    end

    assign pend_mask = r_pend_mask;

`ifdef RF_ARB_STARVE_GUARD_EN
    localparam int SC_W = $clog2(STARVE_LIM + 1);

    logic [SC_W-1:0] r_starve_cnt;

    // Counts consecutive cycles where WB holds the port over buffered work.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_starve_cnt <= '0;
        end else if (ws_rf_we && !w_fifo_empty) begin
            if (r_starve_cnt < SC_W'(STARVE_LIM)) r_starve_cnt <= r_starve_cnt + 1'b1;
        end else begin
            r_starve_cnt <= '0;
        end
    end

    assign arb_stall_req = (r_starve_cnt >= SC_W'(STARVE_LIM));
`else
    assign arb_stall_req = 1'b0;
`endif

endmodule
`default_nettype wire
